pwm_multi_ch: RTL and testbench

Multi-channel PWM generator, parametrised in channel count, duty width and counter rate. It replaces the two-clock single-stage PWM with one clock and a programmable prescaler. A `start`-framed burst of duty words loads shadow registers. Shadow values commit to all channels together, only at a period boundary, so updates are glitch-free. Edge-aligned and center-aligned modes are supported, with per-channel output inversion.

---
 rtl/pwm_multi_ch.sv | 187 ++++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_ch
// Brief    : Multi-channel PWM with a prescaled counter, a burst-loaded shadow
//            duty bank committed at period boundaries, and edge/center modes.
// Revision : 1.0  initial release
// ============================================================================
module pwm_multi_ch #(
    parameter int CH     = 8,
    parameter int DWIDTH = 8,
    parameter int PSC_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DWIDTH-1:0] data,
    input  logic [PSC_W-1:0]  prescale,
    input  logic              center_mode,
    input  logic [CH-1:0]     invert,
    output logic [CH-1:0]     out,
    output logic              loading,
    output logic              period_end
);

    localparam int                c_idx_w    = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(CH - 1);
    localparam logic [DWIDTH-1:0] c_cnt_one  = DWIDTH'(1);
    localparam logic [DWIDTH-1:0] c_cnt_top  = {DWIDTH{1'b1}} - c_cnt_one;
    localparam logic [PSC_W-1:0]  c_psc_one  = PSC_W'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_load = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic               w_cap_en;
    logic [c_idx_w-1:0] w_cap_idx;
    logic               w_burst_start;
    logic               w_burst_done;

    logic [DWIDTH-1:0]  r_shadow [CH];
    logic [DWIDTH-1:0]  r_active [CH];
    logic               r_pending;

    logic [PSC_W-1:0]   r_psc_cnt;
    logic [DWIDTH-1:0]  r_cnt;
    logic               r_dir;
    logic               r_mode;
    logic               w_tick;
    logic               w_at_top;
    logic               w_boundary;
    logic               w_commit;

    logic [CH-1:0]      w_hit;
    logic [CH-1:0]      r_out;
    logic               r_period_end;

    // Loader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cap_en      = 1'b0;
        w_cap_idx     = '0;
        w_burst_start = 1'b0;
        w_burst_done  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_cap_en      = 1'b1;
                    w_burst_start = 1'b1;
                    if (CH == 1) begin
                        w_burst_done = 1'b1;
                    end else begin
                        w_idx_nxt   = c_idx_one;
                        w_state_nxt = c_st_load;
                    end
                end
            end
            c_st_load: begin
                w_cap_en  = 1'b1;
                w_cap_idx = r_idx;
                w_idx_nxt = r_idx + c_idx_one;
                if (r_idx == c_idx_last) begin
                    w_burst_done = 1'b1;
                    w_idx_nxt    = '0;
                    w_state_nxt  = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign w_tick     = (r_psc_cnt == prescale);
    assign w_at_top   = (r_cnt == c_cnt_top);
    assign w_boundary = w_tick & (r_mode ? (r_dir & (r_cnt == '0)) : w_at_top);
    assign w_commit   = w_boundary & r_pending;

    // A fresh burst withdraws any uncommitted set so only complete sets commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_pending <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (w_cap_en && (w_cap_idx == c_idx_w'(i))) begin
                    r_shadow[i] <= data;
                end
                if (w_commit) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_burst_done) begin
                r_pending <= 1'b1;
            end else if (w_burst_start || w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Center mode holds the top value for one extra tick before counting down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc_cnt <= '0;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_mode    <= 1'b0;
        end else begin
            r_psc_cnt <= w_tick ? '0 : (r_psc_cnt + c_psc_one);
            if (w_boundary) begin
                r_cnt  <= '0;
                r_dir  <= 1'b0;
                r_mode <= center_mode;
            end else if (w_tick) begin
                if (!r_mode) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end else if (!r_dir) begin
                    if (w_at_top) begin
                        r_dir <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end else begin
                    r_cnt <= r_cnt - c_cnt_one;
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign w_hit[g] = (r_cnt < r_active[g]) ^ invert[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_out        <= w_hit;
            r_period_end <= w_boundary;
        end
    end

    assign out        = r_out;
    assign period_end = r_period_end;
    assign loading    = (r_state == c_st_load);

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_ch
// Brief    : Self-checking bench for pwm_multi_ch: period-phase reference model
//            compared every clock, plus directed waveform measurements.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_multi_ch;

    localparam int CH     = 8;
    localparam int DWIDTH = 8;
    localparam int PSC_W  = 8;
    localparam int MAX    = (1 << DWIDTH) - 1;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic              start       = 1'b0;
    logic [DWIDTH-1:0] data        = '0;
    logic [PSC_W-1:0]  prescale    = '0;
    logic              center_mode = 1'b0;
    logic [CH-1:0]     invert      = '0;
    logic [CH-1:0]     out;
    logic              loading;
    logic              period_end;

    pwm_multi_ch #(.CH(CH), .DWIDTH(DWIDTH), .PSC_W(PSC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data        (data),
        .prescale    (prescale),
        .center_mode (center_mode),
        .invert      (invert),
        .out         (out),
        .loading     (loading),
        .period_end  (period_end)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: position within the period plus the mode select the count
    int            m_psc     = 0;
    int            m_phase   = 0;
    bit            m_mode    = 1'b0;
    bit            m_pending = 1'b0;
    int            m_idx     = 0;
    int            m_shadow [CH];
    int            m_active [CH];
    logic [CH-1:0] m_out     = '0;
    bit            m_pe      = 1'b0;

    task automatic model_reset();
        m_psc = 0; m_phase = 0; m_mode = 1'b0; m_pending = 1'b0; m_idx = 0;
        m_out = '0; m_pe = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    task automatic model_step();
        int cnt, per;
        bit tick, bnd, done, pend_old;
        int sh_old [CH];
        per = m_mode ? 2 * MAX : MAX;
        cnt = !m_mode ? m_phase : ((m_phase < MAX) ? m_phase : 2 * MAX - 1 - m_phase);
        for (int i = 0; i < CH; i++)
            m_out[i] = ((cnt < m_active[i]) ? 1'b1 : 1'b0) ^ invert[i];
        tick  = (m_psc == int'(prescale));
        m_psc = tick ? 0 : (m_psc + 1) % (1 << PSC_W);
        bnd   = tick && (m_phase == per - 1);
        m_pe  = bnd;
        pend_old = m_pending;
        sh_old   = m_shadow;
        done     = 1'b0;
        if (m_idx == 0) begin
            if (start) begin
                m_shadow[0] = int'(data);
                m_pending   = 1'b0;
                m_idx       = 1;
                if (CH == 1) begin m_idx = 0; done = 1'b1; end
            end
        end else begin
            m_shadow[m_idx] = int'(data);
            m_idx++;
            if (m_idx == CH) begin m_idx = 0; done = 1'b1; end
        end
        if (bnd && pend_old) begin
            m_active  = sh_old;
            m_pending = 1'b0;
        end
        if (done) m_pending = 1'b1;
        if (tick) begin
            if (bnd) begin m_phase = 0; m_mode = center_mode; end
            else m_phase++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(posedge clk) begin
        #1;
        check("out", int'(out), int'(m_out));
        check("loading", int'(loading), int'(m_idx != 0));
        check("period_end", int'(period_end), int'(m_pe));
    end

    // Directed measurement helpers
    int            p_len;
    int            p_ones [CH];
    int            p_run  [CH];
    logic [CH-1:0] p_first;

    task automatic wait_pe(input int limit);
        int cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!period_end && cyc < limit);
        check("pe_seen", int'(period_end), 1);
    endtask

    // Samples from the clock after a period_end through the next period_end
    task automatic count_period(input int limit);
        int cur [CH];
        p_len = 0;
        for (int i = 0; i < CH; i++) begin p_ones[i] = 0; p_run[i] = 0; cur[i] = 0; end
        do begin
            @(posedge clk); #1; p_len++;
            if (p_len == 1) p_first = out;
            for (int i = 0; i < CH; i++) begin
                if (out[i]) begin
                    p_ones[i]++; cur[i]++;
                    if (cur[i] > p_run[i]) p_run[i] = cur[i];
                end else cur[i] = 0;
            end
        end while (!period_end && p_len < limit);
        check("period_bound", int'(period_end), 1);
    endtask

    task automatic burst(input logic [8*CH-1:0] words, input int n, output int lcount);
        lcount = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) lcount += int'(loading);
            start = (i == 0);
            data  = words[8*i +: 8];
        end
        @(negedge clk);
        lcount += int'(loading);
        start = 1'b0;
        data  = DWIDTH'($urandom);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        logic [8*CH-1:0] w;
        logic [7:0] duties [CH];

        // Reset and idle
        invert = 8'h0F;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out", int'(out), 8'h0F);
        check("rst_loading", int'(loading), 0);
        wait_pe(600);
        count_period(600);
        check("edge_period", p_len, 255);

        // Burst load and commit in edge mode
        @(negedge clk); invert = '0;
        wait_pe(600);
        w = 64'h10FF_FEC0_8040_0100;
        burst(w, 8, lc);
        check("loading_cycles", lc, 7);
        check("pre_commit_out", int'(out), 0);
        wait_pe(600);
        count_period(600);
        check("burst_period", p_len, 255);
        duties = '{8'h00, 8'h01, 8'h40, 8'h80, 8'hC0, 8'hFE, 8'hFF, 8'h10};
        for (int i = 0; i < CH; i++) check($sformatf("edge_ones_ch%0d", i), p_ones[i], int'(duties[i]));

        // Prescaler
        @(negedge clk); prescale = 8'd3;
        wait_pe(5000);
        burst(64'h8070_6050_4030_2010, 8, lc);
        wait_pe(5000);
        count_period(5000);
        check("psc_period", p_len, 1020);
        check("psc_ch0_ones", p_ones[0], 64);
        check("psc_ch0_run", p_run[0], 64);

        // Center mode requested mid-period applies only after the boundary
        @(negedge clk); prescale = 8'd0; center_mode = 1'b1;
        count_period(600);
        check("pre_center_period", p_len, 255);
        burst(64'hFF80_0000_0000_0040, 8, lc);
        wait_pe(1200);
        count_period(1200);
        check("center_period", p_len, 510);
        check("center_ch0_ones", p_ones[0], 128);
        check("center_ch0_first", int'(p_first[0]), 1);
        check("center_ch0_run", p_run[0], 64);
        check("center_ch6_ones", p_ones[6], 256);
        check("center_ch7_ones", p_ones[7], 510);
        fork
            count_period(1200);
            begin
                repeat (100) @(negedge clk); center_mode = 1'b0;
                repeat (100) @(negedge clk); center_mode = 1'b1;
            end
        join
        check("center_toggle_period", p_len, 510);

        // Final word on the boundary clock defers the commit one period
        @(negedge clk); center_mode = 1'b0;
        wait_pe(1200);
        wait_pe(600);
        repeat (247) @(posedge clk);
        burst(64'h0000_0000_0000_00A0, 8, lc);
        check("collision_pe", int'(period_end), 1);
        count_period(600);
        check("collision_old_len", p_len, 255);
        check("collision_old_ch0", p_ones[0], 64);
        check("collision_old_ch6", p_ones[6], 128);
        count_period(600);
        check("collision_new_ch0", p_ones[0], 160);
        check("collision_new_ch6", p_ones[6], 0);

        // Reset in the middle of a burst
        @(negedge clk); invert = 8'hA5;
        wait_pe(600);
        burst(64'h1122_3344_5566_7788, 4, lc);
        check("midburst_loading", int'(loading), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            wait_pe(600);
            count_period(600);
            for (int i = 0; i < CH; i++)
                check($sformatf("post_rst_ch%0d", i), p_ones[i], invert[i] ? 255 : 0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            data  = DWIDTH'($urandom);
            start = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 499) == 0)  invert      = CH'($urandom);
            if ($urandom_range(0, 1999) == 0) prescale    = PSC_W'($urandom_range(0, 2));
            if ($urandom_range(0, 999) == 0)  center_mode = 1'($urandom);
        end
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
